// File: rtl/rr_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux_if
// Brief    : Source/sink stream bundle for rr_arb_mux (N sources, one sink).
// Revision : 1.0
// ============================================================================
interface rr_arb_mux_if #(
    parameter int DataWidth = 32,
    parameter int NumInputs = 8
);
    localparam int SelWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1;

    logic [NumInputs-1:0] valid_i;
    logic [DataWidth-1:0] data_i [NumInputs];
    logic [NumInputs-1:0] last_i;
    logic [NumInputs-1:0] ready_o;
    logic                 valid_o;
    logic [DataWidth-1:0] data_o;
    logic [SelWidth-1:0]  sel_o;
    logic                 ready_i;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, sel_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, sel_o
    );
endinterface

`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Brief    : Round-robin N-to-1 stream mux with registered output stage.
//            Define RR_ARB_MUX_BURST_EN to hold the grant until last_i.
// Revision : 1.0
// ============================================================================
module rr_arb_mux #(
    parameter int DataWidth = 32,
    parameter int NumInputs = 8
) (
    input  wire logic    clk_i,
    input  wire logic    rst_i,
    rr_arb_mux_if.slave  bus
);
    localparam int SelWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1;
    localparam logic [SelWidth-1:0] c_last_idx = SelWidth'(NumInputs - 1);

    logic                 r_valid;
    logic [DataWidth-1:0] r_data;
    logic [SelWidth-1:0]  r_sel;
    logic [SelWidth-1:0]  r_ptr;

    logic                 w_accept;
    logic                 w_any;
    logic [SelWidth-1:0]  w_grant;
    logic [SelWidth-1:0]  w_ptr_next;

`ifdef RR_ARB_MUX_BURST_EN
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic [SelWidth-1:0]  r_lock_idx;
`else
    logic                 w_unused_last;
    assign w_unused_last = ^bus.last_i;
`endif

    assign w_accept = !r_valid || bus.ready_i;

    // Scan from the highest offset down so the earliest source in
    // round-robin order (starting at r_ptr) is the last assignment to win.
    always_comb begin
        int j;
        j       = 0;
        w_grant = r_ptr;
        w_any   = 1'b0;
        for (int i = NumInputs - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NumInputs) begin
                j = j - NumInputs;
            end
            if (bus.valid_i[j]) begin
                w_grant = SelWidth'(j);
                w_any   = 1'b1;
            end
        end
`ifdef RR_ARB_MUX_BURST_EN
        if (r_state == LOCKED) begin
            w_grant = r_lock_idx;
            w_any   = bus.valid_i[r_lock_idx];
        end
`endif
    end

    assign w_ptr_next = (w_grant == c_last_idx) ? '0 : w_grant + 1'b1;

    generate
        for (genvar k = 0; k < NumInputs; k++) begin : g_ready
            assign bus.ready_o[k] = !rst_i && w_accept && w_any &&
                                    (w_grant == SelWidth'(k));
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sel      <= '0;
            r_ptr      <= '0;
`ifdef RR_ARB_MUX_BURST_EN
            r_state    <= ARB;
            r_lock_idx <= '0;
`endif
        end else if (w_accept) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= bus.data_i[w_grant];
                r_sel   <= w_grant;
`ifdef RR_ARB_MUX_BURST_EN
                // The pointer only moves once the burst closes.
                if (bus.last_i[w_grant]) begin
                    r_state <= ARB;
                    r_ptr   <= w_ptr_next;
                end else begin
                    r_state    <= LOCKED;
                    r_lock_idx <= w_grant;
                end
`else
                r_ptr   <= w_ptr_next;
`endif
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.sel_o   = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Brief    : Self-checking bench for rr_arb_mux with a scoreboard model.
// Revision : 1.0
// ============================================================================
module tb_rr_arb_mux;
    localparam int DW = 32;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_arb_mux_if #(.DataWidth(DW), .NumInputs(N)) bus ();
    rr_arb_mux_if #(.DataWidth(DW), .NumInputs(3)) bus3 ();

    rr_arb_mux #(.DataWidth(DW), .NumInputs(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    rr_arb_mux #(.DataWidth(DW), .NumInputs(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Source beat generators: beat data = sent*256 + 0xA0 + index.
    int src_left  [N];
    int src_sent  [N];
    bit src_burst [N];

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    s;
    } beat_t;

    beat_t exp_q   [$];
    int    sel_log [$];

    bit m_vo     = 1'b0;
    int m_ptr    = 0;
    bit m_locked = 1'b0;
    int m_lock   = 0;

    function automatic int find_grant(input logic [N-1:0] v, input int p,
                                      input bit locked, input int li,
                                      output bit hit);
        hit        = 1'b0;
        find_grant = 0;
        if (locked) begin
            hit = v[li];
            return li;
        end
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (!hit && v[j]) begin
                hit        = 1'b1;
                find_grant = j;
            end
        end
    endfunction

    always @(negedge clk) begin : driver
        #1;
        for (int k = 0; k < N; k++) begin
            bus.valid_i[k] = (src_left[k] > 0);
            bus.data_i[k]  = DW'(src_sent[k] * 256 + 160 + k);
            bus.last_i[k]  = !src_burst[k] || (src_left[k] == 1);
        end
    end

    always @(posedge clk or posedge rst) begin : model
        bit hit;
        int g;
        if (rst) begin
            m_vo     = 1'b0;
            m_ptr    = 0;
            m_locked = 1'b0;
            m_lock   = 0;
            exp_q.delete();
        end else begin
            g = find_grant(bus.valid_i, m_ptr, m_locked, m_lock, hit);
            if (m_vo && bus.ready_i && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (!m_vo || bus.ready_i) begin
                if (hit) begin
                    exp_q.push_back({bus.data_i[g], 2'(g)});
                    m_vo = 1'b1;
`ifdef RR_ARB_MUX_BURST_EN
                    if (bus.last_i[g]) begin
                        m_locked = 1'b0;
                        m_ptr    = (g + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                        m_lock   = g;
                    end
`else
                    m_ptr = (g + 1) % N;
`endif
                    src_left[g]--;
                    src_sent[g]++;
                end else begin
                    m_vo = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        bit           hit;
        int           g;
        logic [N-1:0] exp_rdy;
        #3;
        g       = find_grant(bus.valid_i, m_ptr, m_locked, m_lock, hit);
        exp_rdy = '0;
        if (!rst && (!m_vo || bus.ready_i) && hit) exp_rdy[g] = 1'b1;
        n_checks++;
        if (bus.ready_o !== exp_rdy)
            $display("FAIL ready_o @%0t: got %b expected %b", $time, bus.ready_o, exp_rdy);
        else n_pass++;
        n_checks++;
        if (bus.valid_o !== m_vo)
            $display("FAIL valid_o @%0t: got %b expected %b", $time, bus.valid_o, m_vo);
        else n_pass++;
        if (bus.valid_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0)
                $display("FAIL scoreboard @%0t: got beat data=%h sel=%0d expected none",
                         $time, bus.data_o, bus.sel_o);
            else if ({bus.data_o, bus.sel_o} !== exp_q[0])
                $display("FAIL scoreboard @%0t: got data=%h sel=%0d expected data=%h sel=%0d",
                         $time, bus.data_o, bus.sel_o, exp_q[0].d, exp_q[0].s);
            else n_pass++;
            if (bus.ready_i === 1'b1 && !rst) sel_log.push_back(int'(bus.sel_o));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.ready_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_left[k]  = 0;
            src_sent[k]  = 0;
            src_burst[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sel_log.delete();
    endtask

    task automatic test_reset();
        int obs;
        src_left[1] = 1;
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.sel_o !== '0)
            $display("FAIL reset_outputs: got valid=%b data=%h sel=%0d expected 0/0/0",
                     bus.valid_o, bus.data_o, bus.sel_o);
        else n_pass++;
        n_checks++;
        if (bus.ready_o !== '0)
            $display("FAIL reset_ready: got %b expected 0000", bus.ready_o);
        else n_pass++;
        @(negedge clk);
        rst         = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        obs = (sel_log.size() == 1) ? sel_log[0] : -1;
        n_checks++;
        if (obs !== 1)
            $display("FAIL reset_held_beat: got sel=%0d expected 1", obs);
        else n_pass++;
    endtask

    task automatic test_basic();
        int exp_seq [$] = '{0, 2, 3, 0, 1};
        bit ok;
        do_reset();
        bus.ready_i = 1'b1;
        src_left[0] = 1;
        src_left[2] = 1;
        @(negedge clk); #2;
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.sel_o !== 2'd0 || bus.data_o !== 32'hA0)
            $display("FAIL basic_first: got v=%b sel=%0d data=%h expected v=1 sel=0 data=a0",
                     bus.valid_o, bus.sel_o, bus.data_o);
        else n_pass++;
        @(negedge clk); #2;
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.sel_o !== 2'd2 || bus.data_o !== 32'hA2)
            $display("FAIL basic_second: got v=%b sel=%0d data=%h expected v=1 sel=2 data=a2",
                     bus.valid_o, bus.sel_o, bus.data_o);
        else n_pass++;
        src_left[3] = 1;
        repeat (3) @(negedge clk);
        src_left[0] = 1;
        src_left[1] = 1;
        repeat (4) @(negedge clk);
        #2;
        ok = (sel_log.size() == exp_seq.size());
        foreach (exp_seq[i]) if (ok && sel_log[i] != exp_seq[i]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL basic_wrap_seq: got %p expected %p", sel_log, exp_seq);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int exp_seq [$] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bit ok;
        do_reset();
        bus.ready_i = 1'b1;
        for (int k = 0; k < N; k++) src_left[k] = 2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #2;
            n_checks++;
            if (bus.valid_o !== 1'b1 || int'(bus.sel_o) != exp_seq[i])
                $display("FAIL b2b_beat%0d: got v=%b sel=%0d expected v=1 sel=%0d",
                         i, bus.valid_o, bus.sel_o, exp_seq[i]);
            else n_pass++;
        end
        repeat (4) @(negedge clk);
        #2;
        ok = (sel_log.size() == exp_seq.size());
        foreach (exp_seq[i]) if (ok && sel_log[i] != exp_seq[i]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL b2b_seq: got %p expected %p", sel_log, exp_seq);
        else n_pass++;
    endtask

    task automatic test_stall();
        int exp_seq [$] = '{1, 2};
        bit ok;
        do_reset();
        bus.ready_i = 1'b1;
        src_left[1] = 1;
        src_left[2] = 1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        repeat (3) begin
            #2;
            n_checks++;
            if (bus.valid_o !== 1'b1 || bus.sel_o !== 2'd1 || bus.data_o !== 32'hA1 ||
                bus.ready_o !== '0)
                $display("FAIL stall_hold: got v=%b sel=%0d data=%h rdy=%b expected v=1 sel=1 data=a1 rdy=0000",
                         bus.valid_o, bus.sel_o, bus.data_o, bus.ready_o);
            else n_pass++;
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        @(negedge clk); #2;
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.sel_o !== 2'd2 || bus.data_o !== 32'hA2)
            $display("FAIL stall_release: got v=%b sel=%0d data=%h expected v=1 sel=2 data=a2",
                     bus.valid_o, bus.sel_o, bus.data_o);
        else n_pass++;
        repeat (3) @(negedge clk);
        #2;
        ok = (sel_log.size() == exp_seq.size());
        foreach (exp_seq[i]) if (ok && sel_log[i] != exp_seq[i]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL stall_seq: got %p expected %p", sel_log, exp_seq);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int obs;
        do_reset();
        bus.ready_i = 1'b1;
        src_left[3] = 1;
        @(negedge clk); #2;
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.sel_o !== 2'd3)
            $display("FAIL areset_pre: got v=%b sel=%0d expected v=1 sel=3", bus.valid_o, bus.sel_o);
        else n_pass++;
        src_left[2] = 1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.sel_o !== '0)
            $display("FAIL areset_immediate: got v=%b data=%h sel=%0d expected 0/0/0",
                     bus.valid_o, bus.data_o, bus.sel_o);
        else n_pass++;
        @(negedge clk); #2;
        n_checks++;
        if (bus.ready_o !== '0 || bus.valid_i[2] !== 1'b1)
            $display("FAIL areset_no_accept: got rdy=%b expected 0000 with src2 valid", bus.ready_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        obs = (sel_log.size() == 1) ? sel_log[0] : -1;
        n_checks++;
        if (obs !== 2)
            $display("FAIL areset_kept_beat: got sel=%0d expected 2", obs);
        else n_pass++;
    endtask

    task automatic test_burst();
`ifdef RR_ARB_MUX_BURST_EN
        int exp_seq [$] = '{1, 1, 1, 2, 2, 2};
`else
        int exp_seq [$] = '{1, 2, 1, 2, 1, 2};
`endif
        bit ok;
        do_reset();
        bus.ready_i  = 1'b1;
        src_burst[1] = 1'b1;
        src_left[1]  = 3;
        src_left[2]  = 3;
        repeat (9) @(negedge clk);
        #2;
        ok = (sel_log.size() == exp_seq.size());
        foreach (exp_seq[i]) if (ok && sel_log[i] != exp_seq[i]) ok = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL burst_seq: got %p expected %p", sel_log, exp_seq);
        else n_pass++;
    endtask

    task automatic test_wrap3();
        int exp_seq [5] = '{0, 1, 2, 0, 1};
        do_reset();
        bus3.ready_i = 1'b1;
        bus3.valid_i = 3'b111;
        bus3.last_i  = 3'b111;
        for (int k = 0; k < 3; k++) bus3.data_i[k] = DW'(k);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            n_checks++;
            if (bus3.valid_o !== 1'b1 || int'(bus3.sel_o) != exp_seq[i] ||
                bus3.data_o !== DW'(exp_seq[i]))
                $display("FAIL wrap3_beat%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d",
                         i, bus3.valid_o, bus3.sel_o, bus3.data_o, exp_seq[i]);
            else n_pass++;
        end
        bus3.valid_i = '0;
    endtask

    initial begin
        bus.ready_i  = 1'b0;
        bus.valid_i  = '0;
        bus.last_i   = '0;
        for (int k = 0; k < N; k++) begin
            bus.data_i[k] = '0;
            src_left[k]   = 0;
            src_sent[k]   = 0;
            src_burst[k]  = 1'b0;
        end
        bus3.ready_i = 1'b0;
        bus3.valid_i = '0;
        bus3.last_i  = '0;
        for (int k = 0; k < 3; k++) bus3.data_i[k] = '0;

        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_burst();
        test_wrap3();

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_arb_mux.md
# rr_arb_mux

Round-robin arbitrated N-to-1 stream multiplexer with a registered output stage: the gathering counterpart of the `demux` steering block. Each of N sources presents a valid/ready stream. One source is granted per accepted beat, and its data is forwarded with the source index to a single valid/ready sink. The block sits wherever multiple producers (issue ports, LSU/fetch requesters, debug) share one downstream consumer.

## Interface

Parameters:
- `DataWidth`, default 32: width of each data beat.
- `NumInputs`, default 8: number of source ports, ≥1.
- `SelWidth`, localparam: `(NumInputs > 1) ? $clog2(NumInputs) : 1`.

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `valid_i` input [NumInputs]: per-source beat valid.
- `data_i` input [DataWidth-1:0] × [NumInputs]: per-source data, unpacked array.
- `last_i` input [NumInputs]: per-source end-of-burst. Ignored unless `RR_ARB_MUX_BURST_EN` is defined.
- `ready_o` output [NumInputs]: per-source accept.
- `valid_o` output 1: output beat valid (registered).
- `data_o` output [DataWidth-1:0]: output data (registered).
- `sel_o` output [SelWidth-1:0]: index of the source that produced `data_o` (registered).
- `ready_i` input 1: sink accept.

## Operation

- Handshake on both sides is valid/ready. A beat transfers when valid and ready are both high at a clock edge.
- Sources must hold `data_i[k]` and `valid_i[k]` stable until `ready_o[k]`.
- `accept = !valid_o || ready_i`, so the output register can load this cycle.
- Grant search:
  - Start at priority pointer `ptr`.
  - Scan `ptr, ptr+1, …, NumInputs-1, 0, …, ptr-1`.
  - The first index with `valid_i` set is granted `g`.
- `ready_o[g] = accept && any(valid_i)`. All other `ready_o` bits are 0. With no valid input, all `ready_o` are 0.
- On transfer from `g`:
  - `data_o <= data_i[g]`, `sel_o <= g`, `valid_o <= 1`.
  - `ptr <= (g == NumInputs-1) ? 0 : g+1`. This wraps for non-power-of-2 counts; `ptr` never holds a value ≥ NumInputs.
- If `accept` is true and no input is valid: `valid_o <= 0`. The previous beat is drained; `data_o` and `sel_o` hold.
- If `valid_o && !ready_i`:
  - `data_o`, `sel_o` and `valid_o` hold stable.
  - All `ready_o` are 0.
  - `ptr` is unchanged.
- `NumInputs == 1`: no arbitration; `sel_o` is constant 0 and `ptr` is constant 0.

## Timing

- Reset values: `valid_o = 0`, `data_o = '0`, `sel_o = 0`, `ptr = 0`, lock state cleared. `ready_o` is combinational and is therefore all-zero during reset.
- Latency: 1 cycle from an input transfer to `valid_o` high.
- Throughput: 1 beat/cycle when `ready_i` is held high.
- `ready_o` depends combinationally on `valid_i`, `ready_i`, `ptr` and lock state. There is no combinational path from any input to `valid_o`, `data_o` or `sel_o`.
- Simultaneous drain and load: with `valid_o && ready_i` and a valid source, the current beat leaves and the new beat loads at the same edge, with no bubble.
- Reset mid-operation: a beat held in the output register is discarded. Sources see no acceptance during reset and keep their beats.

## Configuration

- `RR_ARB_MUX_BURST_EN` defined:
  - Two states: `ARB` and `LOCKED`.
  - In `ARB`: a transfer from `g` with `last_i[g] = 0` moves to `LOCKED` with `lock_idx <= g`, and `ptr` is not advanced.
  - In `LOCKED`: only `lock_idx` is eligible. Other sources get `ready_o = 0` even if `lock_idx` is idle.
  - A transfer from `lock_idx` with `last_i = 1` returns to `ARB` and sets `ptr <= lock_idx+1` (wrapped).
  - A single-beat burst (`last_i = 1` on the first beat) behaves as in non-burst mode.
- Undefined:
  - `last_i` is ignored and there is no lock state.
  - Arbitration happens on every beat.

## Test plan

- Reset, then `NumInputs=4`, sources 0 and 2 valid (`0xA0`, `0xA2`), `ready_i=1` → first beat `data_o=0xA0`, `sel_o=0`; next cycle `data_o=0xA2`, `sel_o=2`; `ptr` becomes 3.
- All four sources are continuously valid with `ready_i=1` → `sel_o` sequence is 0,1,2,3,0,1 with no bubbles.
- `ptr=3`, only source 3 valid, transfer → `ptr` wraps to 0. With `NumInputs=3`, a transfer from source 2 gives `ptr=0`.
- Hold `ready_i=0` for 3 cycles with `valid_o=1` → `data_o` and `sel_o` stable, all `ready_o=0`. On `ready_i=1` the stored beat drains and the next beat loads on the same edge.
- Assert `rst_i` asynchronously mid-cycle while `valid_o=1` → `valid_o`, `data_o` and `sel_o` go to 0 immediately, without waiting for a clock edge.
- `RR_ARB_MUX_BURST_EN` defined: source 1 sends 3 beats (`last_i` on the third) while source 2 is valid throughout → `sel_o` is 1,1,1, then 2. With the macro undefined, the same stimulus gives `sel_o` 1,2,1,2,1.
